screen_arbiter: RTL

Single-port arbiter that shares the Hack screen RAM (8K x 16 words) between the CPU data port and the video scan-out fetcher inside Nand2Tetris_top. Video reads have fixed priority so the raster never misses a fetch. A starvation guard bounds CPU wait. Each side sees a simple req/ack handshake, and the RAM sees one access per cycle with 1-cycle read latency.

---
 rtl/screen_pkg.sv | 19 +
 rtl/screen_arb_starve.sv | 48 ++++
 rtl/screen_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/screen_pkg.sv
// Shared types and widths for the Hack screen RAM arbiter.
//   SCREEN_ADDR_W / SCREEN_DATA_W : screen RAM geometry (8K x 16)
//   STREAK_W                      : width of the video-streak counter
//   STATS_W                       : width of the CPU wait statistic
//   owner_t                       : owner of the RAM port in a given cycle
package screen_pkg;

    localparam int unsigned SCREEN_ADDR_W = 13;
    localparam int unsigned SCREEN_DATA_W = 16;
    localparam int unsigned STREAK_W      = 4;
    localparam int unsigned STATS_W       = 16;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_VID
    } owner_t;

endpackage

// File: rtl/screen_arb_starve.sv
// Starvation guard: counts consecutive video grants taken while the CPU was
// eligible, and forces the CPU in once the count reaches STARVE_MAX.
//   clk, reset_n  : clock, async active-low reset
//   cpu_req_i     : CPU request level
//   cpu_elig_i    : CPU eligible this cycle (request and not outstanding)
//   cpu_gnt_i     : CPU granted this cycle
//   vid_gnt_i     : video granted this cycle
//   force_cpu_c   : combinational, streak has reached STARVE_MAX
module screen_arb_starve
    import screen_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic cpu_req_i,
    input  logic cpu_elig_i,
    input  logic cpu_gnt_i,
    input  logic vid_gnt_i,
    output logic force_cpu_c
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_MAX);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;

    // Streak next-state: clear on CPU service or request drop, saturate at max.
    always_comb begin
        streak_d = streak_q;
        if (cpu_gnt_i || !cpu_req_i) begin
            streak_d = '0;
        end else if (vid_gnt_i && cpu_elig_i && (streak_q < STREAK_MAX)) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign force_cpu_c = (streak_q == STREAK_MAX);

endmodule

// File: rtl/screen_arbiter.sv
// Single-port arbiter sharing the Hack screen RAM between the CPU data port
// and the video fetcher. Video has fixed priority, bounded by a starvation
// guard. Grant drives ram_* combinationally; ack pulses the following cycle.
// Optional feature: define SCREEN_ARB_STATS_EN to enable the CPU wait counter.
//   clk, reset_n                           : clock, async active-low reset
//   cpu_req/we/addr/wdata, cpu_ack/rdata   : CPU req/ack port
//   vid_req/addr, vid_ack/rdata            : video read port
//   ram_addr/we/wdata, ram_rdata           : RAM port (1-cycle read latency)
//   stats_cpu_wait                         : CPU stall cycles (0 if disabled)
module screen_arbiter
    import screen_pkg::*;
#(
    parameter int unsigned ADDR_W     = SCREEN_ADDR_W,
    parameter int unsigned DATA_W     = SCREEN_DATA_W,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic               cpu_ack,
    output logic [DATA_W-1:0]  cpu_rdata,
    input  logic               vid_req,
    input  logic [ADDR_W-1:0]  vid_addr,
    output logic               vid_ack,
    output logic [DATA_W-1:0]  vid_rdata,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_we,
    output logic [DATA_W-1:0]  ram_wdata,
    input  logic [DATA_W-1:0]  ram_rdata,
    output logic [STATS_W-1:0] stats_cpu_wait
);

    owner_t              own_q;
    owner_t              own_d;
    logic                active_q;
    logic                cpu_rd_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_wdata_q;
    logic [DATA_W-1:0]   cpu_rdata_q;
    logic [DATA_W-1:0]   vid_rdata_q;
    logic                cpu_elig;
    logic                vid_elig;
    logic                cpu_gnt;
    logic                vid_gnt;
    logic                force_cpu;

    // A side granted last cycle is in its ack cycle and may not be re-granted.
    assign cpu_elig = cpu_req && (own_q != OWN_CPU);
    assign vid_elig = vid_req && (own_q != OWN_VID);

    screen_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_req_i   (cpu_req),
        .cpu_elig_i  (cpu_elig),
        .cpu_gnt_i   (cpu_gnt),
        .vid_gnt_i   (vid_gnt),
        .force_cpu_c (force_cpu)
    );

    // State register: grant owner plus response bookkeeping.
    // active_q holds off grants until the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            own_q       <= OWN_NONE;
            active_q    <= 1'b0;
            cpu_rd_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            own_q       <= own_d;
            active_q    <= 1'b1;
            cpu_rd_q    <= cpu_gnt && !cpu_we;
            ram_addr_q  <= ram_addr;
            ram_wdata_q <= ram_wdata;
            cpu_rdata_q <= cpu_rdata;
            vid_rdata_q <= vid_rdata;
        end
    end

    // Next-state: video first unless the starvation guard forces the CPU.
    always_comb begin
        own_d = OWN_NONE;
        if (active_q) begin
            if (vid_elig && !(cpu_elig && force_cpu)) begin
                own_d = OWN_VID;
            end else if (cpu_elig) begin
                own_d = OWN_CPU;
            end
        end
    end

    assign cpu_gnt = (own_d == OWN_CPU);
    assign vid_gnt = (own_d == OWN_VID);

    // Output decode: RAM port follows the grant; address/wdata hold when idle.
    always_comb begin
        ram_addr  = ram_addr_q;
        ram_we    = 1'b0;
        ram_wdata = ram_wdata_q;
        unique case (own_d)
            OWN_CPU: begin
                ram_addr  = cpu_addr;
                ram_we    = cpu_we;
                ram_wdata = cpu_wdata;
            end
            OWN_VID: begin
                ram_addr  = vid_addr;
            end
            default: begin
            end
        endcase
    end

    // Responses: RAM data arrives in the ack cycle, so pass it through then.
    assign cpu_ack   = (own_q == OWN_CPU);
    assign vid_ack   = (own_q == OWN_VID);
    assign cpu_rdata = cpu_rd_q ? ram_rdata : cpu_rdata_q;
    assign vid_rdata = vid_ack ? ram_rdata : vid_rdata_q;

`ifdef SCREEN_ARB_STATS_EN
    logic [STATS_W-1:0] stats_q;

    // Count CPU cycles spent requesting but neither granted nor acked.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stats_q <= '0;
        end else if (active_q && cpu_req && !cpu_gnt && !cpu_ack && (stats_q != '1)) begin
            stats_q <= stats_q + STATS_W'(1);
        end
    end

    assign stats_cpu_wait = stats_q;
`else
    assign stats_cpu_wait = '0;
`endif

endmodule
